bus_master: RTL and testbench

- Initiator side of the local DMA bus. It sits between the host-side command/FIFO logic and the bus_slave endpoint.
- Accepts one burst command at a time: direction, channel 0/1, and length in words.
- Runs the address phase, write burst or read burst, and termination sequence on the stb/we/m_rdy/ack/abort/s_rdy bus.
- Reports the number of words moved and whether the slave aborted.

---
 rtl/bus_master.sv | 208 ++++++++++++++++++++
 tb/tb_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// bus_master: initiator side of the local DMA bus.
// Runs one write or read burst per command and reports words moved.
module bus_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic             cmd_chan_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             done_o,
  output logic [LEN_W-1:0] done_count_o,
  output logic             done_abort_o,
  input  logic [31:0]      src_dat_i,
  input  logic             src_empty_i,
  output logic             src_rd_o,
  output logic [31:0]      rd_dat_o,
  output logic             rd_valid_o,
  input  logic [1:0]       req_w_i,
  input  logic [1:0]       req_r_i,
  output logic             stb_o,
  output logic             we_o,
  output logic             m_rdy_o,
  output logic [31:0]      dat_o,
  output logic             dat_o_enable_o,
  input  logic             ack_i,
  input  logic             abort_i,
  input  logic             s_rdy_i,
  input  logic [31:0]      dat_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_WAIT, S_ADDR, S_WR_BURST,
    S_RD_BURST, S_RD_DRAIN, S_END
  } state_t;

  state_t state, state_n;

  logic             we_q, we_d;
  logic             chan_q, chan_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] sent, sent_d;
  logic [LEN_W-1:0] issued, issued_d;
  logic [LEN_W-1:0] recv, recv_d;
  logic             first, first_d;
  logic             abort_q, abort_d;
  logic             stb_d, m_rdy_d, we_bus_d, oe_d;
  logic [31:0]      dat_d, rd_dat_d;
  logic             rd_valid_d;
  logic             done_d, dab_d;
  logic [LEN_W-1:0] cnt_d;
  logic             req;

  assign cmd_ready_o = (state == S_IDLE);
  assign req = we_q ? req_w_i[chan_q] : req_r_i[chan_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= S_IDLE;
      we_q           <= 1'b0;
      chan_q         <= 1'b0;
      len_q          <= '0;
      sent           <= '0;
      issued         <= '0;
      recv           <= '0;
      first          <= 1'b0;
      abort_q        <= 1'b0;
      stb_o          <= 1'b0;
      we_o           <= 1'b0;
      m_rdy_o        <= 1'b0;
      dat_o          <= '0;
      dat_o_enable_o <= 1'b0;
      rd_dat_o       <= '0;
      rd_valid_o     <= 1'b0;
      done_o         <= 1'b0;
      done_count_o   <= '0;
      done_abort_o   <= 1'b0;
    end else begin
      state          <= state_n;
      we_q           <= we_d;
      chan_q         <= chan_d;
      len_q          <= len_d;
      sent           <= sent_d;
      issued         <= issued_d;
      recv           <= recv_d;
      first          <= first_d;
      abort_q        <= abort_d;
      stb_o          <= stb_d;
      we_o           <= we_bus_d;
      m_rdy_o        <= m_rdy_d;
      dat_o          <= dat_d;
      dat_o_enable_o <= oe_d;
      rd_dat_o       <= rd_dat_d;
      rd_valid_o     <= rd_valid_d;
      done_o         <= done_d;
      done_count_o   <= cnt_d;
      done_abort_o   <= dab_d;
    end
  end

  always_comb begin
    state_n    = state;
    we_d       = we_q;
    chan_d     = chan_q;
    len_d      = len_q;
    sent_d     = sent;
    issued_d   = issued;
    recv_d     = recv;
    first_d    = first;
    abort_d    = abort_q;
    stb_d      = stb_o;
    m_rdy_d    = 1'b0;
    dat_d      = dat_o;
    rd_dat_d   = rd_dat_o;
    rd_valid_d = 1'b0;
    src_rd_o   = 1'b0;

    // s_rdy trails ack by a cycle, so capture spans burst and drain
    if ((state == S_RD_BURST || state == S_RD_DRAIN) &&
        s_rdy_i && recv < len_q) begin
      rd_dat_d   = dat_i;
      rd_valid_d = 1'b1;
      recv_d     = recv + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d     = cmd_we_i;
          chan_d   = cmd_chan_i;
          len_d    = cmd_len_i;
          sent_d   = '0;
          issued_d = '0;
          recv_d   = '0;
          abort_d  = 1'b0;
          first_d  = 1'b1;
          state_n  = (cmd_len_i == '0) ? S_END : S_REQ_WAIT;
        end
      end
      S_REQ_WAIT: begin
        if (req) begin
          stb_d   = 1'b1;
          dat_d   = {31'b0, chan_q};
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        first_d = 1'b1;
        state_n = we_q ? S_WR_BURST : S_RD_BURST;
      end
      S_WR_BURST: begin
        if (sent == len_q) begin
          stb_d   = 1'b0;
          state_n = S_END;
        end else if (first && abort_i) begin
          stb_d   = 1'b0;
          abort_d = 1'b1;
          state_n = S_END;
        end else if (!ack_i && !first) begin
          stb_d   = 1'b0;
          state_n = S_END;
        end else if (ack_i) begin
          first_d = 1'b0;
          if (!src_empty_i) begin
            src_rd_o = 1'b1;
            m_rdy_d  = 1'b1;
            dat_d    = src_dat_i;
            sent_d   = sent + 1'b1;
          end
        end
      end
      S_RD_BURST: begin
        if (first && abort_i) begin
          stb_d   = 1'b0;
          abort_d = 1'b1;
          state_n = S_END;
        end else if (ack_i) begin
          first_d  = 1'b0;
          issued_d = issued + 1'b1;
          if (issued + 1'b1 == len_q) begin
            stb_d   = 1'b0;
            state_n = S_RD_DRAIN;
          end
        end else if (!first) begin
          stb_d   = 1'b0;
          state_n = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (recv_d == issued) state_n = S_END;
      end
      S_END: begin
        stb_d   = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    we_bus_d = stb_d & we_d;
    oe_d     = (stb_d & we_d) | (state_n == S_ADDR);
    done_d   = (state_n == S_END);
    cnt_d    = done_d ? (we_d ? sent_d : recv_d) : '0;
    dab_d    = done_d & abort_d;
  end

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed checks of bus_master against a small
// behavioural slave, source FIFO and sink monitor.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic        cmd_chan = 1'b0;
  logic [15:0] cmd_len = '0;
  logic        done;
  logic [15:0] done_count;
  logic        done_abort;
  logic [31:0] src_dat;
  logic        src_empty;
  logic        src_rd;
  logic [31:0] rd_dat;
  logic        rd_valid;
  logic [1:0]  req_w = 2'b00;
  logic [1:0]  req_r = 2'b00;
  logic        stb, we, m_rdy, dat_oe;
  logic [31:0] dat;
  logic        ack, abort;
  logic        s_rdy = 1'b0;
  logic [31:0] s_dat = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_master #(.LEN_W(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_chan_i(cmd_chan), .cmd_len_i(cmd_len),
    .done_o(done), .done_count_o(done_count),
    .done_abort_o(done_abort),
    .src_dat_i(src_dat), .src_empty_i(src_empty), .src_rd_o(src_rd),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid),
    .req_w_i(req_w), .req_r_i(req_r),
    .stb_o(stb), .we_o(we), .m_rdy_o(m_rdy),
    .dat_o(dat), .dat_o_enable_o(dat_oe),
    .ack_i(ack), .abort_i(abort), .s_rdy_i(s_rdy), .dat_i(s_dat)
  );

  // write source: FWFT fifo, tail moved by stimulus, head by pops
  logic [31:0] sf [0:63];
  int sh = 0;
  int st = 0;
  assign src_dat = sf[sh];
  assign src_empty = (sh == st);
  always @(posedge clk) if (src_rd) sh <= sh + 1;

  // slave model
  logic [31:0] rf [0:63];
  int rh = 0;
  int rt = 0;
  logic sst = 1'b0;
  logic s_we = 1'b0;
  logic s_chan = 1'b0;
  logic abort_mode = 1'b0;
  logic [31:0] wl [0:63];
  int wn = 0;

  assign ack = sst && !abort_mode && (s_we || rh != rt);
  assign abort = sst && abort_mode;

  always @(posedge clk) begin
    if (m_rdy) begin
      wl[wn] <= dat;
      wn <= wn + 1;
    end
    s_rdy <= 1'b0;
    if (!sst) begin
      if (stb) begin
        sst <= 1'b1;
        s_we <= we;
        s_chan <= dat[0];
      end
    end else if (!stb) begin
      sst <= 1'b0;
    end else if (ack && !s_we) begin
      s_rdy <= 1'b1;
      s_dat <= rf[rh];
      rh <= rh + 1;
    end
  end

  // monitor
  int stb_hi = 0, ack_cnt = 0, srd_cnt = 0, mcnt = 0, dn = 0, rn = 0;
  logic prev_m = 1'b0;
  logic stb_after = 1'b1;
  logic [15:0] dcount = '0;
  logic dabort = 1'b0;
  logic [31:0] rl [0:63];

  always @(negedge clk) begin
    if (stb) stb_hi++;
    if (stb && ack) ack_cnt++;
    if (src_rd) srd_cnt++;
    if (prev_m) stb_after = stb;
    prev_m = m_rdy;
    if (m_rdy) mcnt++;
    if (rd_valid) begin
      rl[rn] = rd_dat;
      rn++;
    end
    if (done) begin
      dn++;
      dcount = done_count;
      dabort = done_abort;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic ch,
                      input logic [15:0] len);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_we = w;
    cmd_chan = ch;
    cmd_len = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (dn == d0 && n < 200) begin
      step();
      n++;
    end
    if (dn == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int d0, sb, wb, rb, mb, sr, ab;

  initial begin
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_stb", stb, 0);
    check("rst_mrdy", m_rdy, 0);
    check("rst_done", done, 0);
    check("rst_oe", dat_oe, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: write ch0, len 4, request withheld for 5 cycles
    for (int i = 0; i < 4; i++) begin
      sf[st] = 32'hA0 + i;
      st++;
    end
    d0 = dn; sb = stb_hi; wb = wn;
    send(1'b1, 1'b0, 16'd4);
    repeat (5) step();
    check("t1_no_stb_wo_req", stb_hi - sb, 0);
    req_w = 2'b01;
    step();
    check("t1_addr_stb", stb, 1);
    check("t1_addr_dat", dat, 0);
    check("t1_addr_mrdy", m_rdy, 0);
    check("t1_addr_oe", dat_oe, 1);
    wait_done(d0);
    check("t1_words", wn - wb, 4);
    for (int i = 0; i < 4; i++)
      check("t1_word", wl[wb + i], 32'hA0 + i);
    check("t1_stb_after_last", stb_after, 0);
    check("t1_count", dcount, 4);
    check("t1_abort", dabort, 0);
    req_w = 2'b00;
    step();

    // 2: write ch1, slave aborts in its ack cycle
    abort_mode = 1'b1;
    sf[st] = 32'hC0;
    st++;
    d0 = dn; sb = stb_hi; mb = mcnt; sr = srd_cnt;
    req_w = 2'b10;
    send(1'b1, 1'b1, 16'd2);
    wait_done(d0);
    check("t2_chan", s_chan, 1);
    check("t2_stb_cycles", stb_hi - sb, 2);
    check("t2_mrdy", mcnt - mb, 0);
    check("t2_src_rd", srd_cnt - sr, 0);
    check("t2_count", dcount, 0);
    check("t2_abort", dabort, 1);
    abort_mode = 1'b0;
    req_w = 2'b00;
    st = sh;
    step();

    // 3: read ch1, len 3, slave holds 6 words
    for (int i = 0; i < 6; i++) begin
      rf[rt] = 32'hB0 + i;
      rt++;
    end
    d0 = dn; rb = rn; ab = ack_cnt;
    req_r = 2'b10;
    send(1'b0, 1'b1, 16'd3);
    wait_done(d0);
    check("t3_acks", ack_cnt - ab, 3);
    check("t3_words", rn - rb, 3);
    for (int i = 0; i < 3; i++)
      check("t3_word", rl[rb + i], 32'hB0 + i);
    check("t3_left", rt - rh, 3);
    check("t3_count", dcount, 3);
    req_r = 2'b00;
    step();

    // 4: read ch0, len 8, slave runs dry after 5
    rt = rh;
    for (int i = 0; i < 5; i++) begin
      rf[rt] = 32'hD0 + i;
      rt++;
    end
    d0 = dn; rb = rn;
    req_r = 2'b01;
    send(1'b0, 1'b0, 16'd8);
    wait_done(d0);
    check("t4_words", rn - rb, 5);
    check("t4_first", rl[rb], 32'hD0);
    check("t4_last", rl[rb + 4], 32'hD4);
    check("t4_count", dcount, 5);
    check("t4_abort", dabort, 0);
    step();
    check("t4_ready_after", cmd_ready, 1);
    req_r = 2'b00;

    // 5: zero length
    sb = stb_hi;
    cmd_we = 1'b1;
    cmd_chan = 1'b0;
    cmd_len = 16'd0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("t5_done", done, 1);
    check("t5_count", done_count, 0);
    repeat (3) step();
    check("t5_no_stb", stb_hi - sb, 0);

    // 6: reset mid write burst
    for (int i = 0; i < 8; i++) begin
      sf[st] = 32'hE0 + i;
      st++;
    end
    mb = mcnt;
    req_w = 2'b01;
    send(1'b1, 1'b0, 16'd6);
    for (int n = 0; n < 50 && (mcnt - mb) < 2; n++) step();
    check("t6_burst_started", (mcnt - mb) >= 2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stb", stb, 0);
    check("t6_rst_mrdy", m_rdy, 0);
    check("t6_rst_src_rd", src_rd, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_ready", cmd_ready, 1);
    st = sh;
    sf[st] = 32'hF0;
    sf[st + 1] = 32'hF1;
    st = st + 2;
    d0 = dn; wb = wn;
    send(1'b1, 1'b0, 16'd2);
    wait_done(d0);
    check("t6_count", dcount, 2);
    check("t6_words", wn - wb, 2);
    check("t6_w0", wl[wb], 32'hF0);
    check("t6_w1", wl[wb + 1], 32'hF1);
    req_w = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
